// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame configuration and received-word bundle for uart_rx
//  RX_IN      serial line, idle high (already synchronised)
//  PAR_EN     1 = parity bit present
//  PAR_TYP    0 = even, 1 = odd
//  Prescale   oversample ratio (8, 16 or 32)
//  P_DATA     last good received word
//  data_valid one-cycle pulse when P_DATA holds a good frame
//  par_err    parity mismatch on last frame
//  stp_err    stop bit sampled 0 on last frame
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    // master: pad/configuration side that drives the line and consumes the word
    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, par_err, stp_err
    );

    // slave: the receiver itself
    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with 3-sample majority vote, parity and stop checks
//  CLK  oversampling clock, Prescale ticks per bit
//  RST  asynchronous reset, active-low
//  rx   uart_rx_if.slave: RX_IN/PAR_EN/PAR_TYP/Prescale in, P_DATA/data_valid/par_err/stp_err out
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave rx
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [5:0]            pre_q, pre_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic [5:0] half;
    logic       last_edge;
    logic       maj_reg;
    logic       maj_stop;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        pre_d        = pre_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;

        half      = {1'b0, pre_q[5:1]};
        last_edge = (edge_cnt_q == pre_q - 6'd1);
        maj_reg   = maj3(samp_q[0], samp_q[1], samp_q[2]);
        // The stop decision happens on the third sample cycle itself, so the
        // live line value stands in for the not-yet-registered third sample.
        maj_stop  = maj3(samp_q[0], samp_q[1], rx.RX_IN);

        if (state_q != S_IDLE) begin
            edge_cnt_d = last_edge ? 6'd0 : edge_cnt_q + 6'd1;
            if (edge_cnt_q == half - 6'd1) samp_d[0] = rx.RX_IN;
            if (edge_cnt_q == half)        samp_d[1] = rx.RX_IN;
            if (edge_cnt_q == half + 6'd1) samp_d[2] = rx.RX_IN;
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = 6'd0;
                if (!rx.RX_IN) begin
                    // Detection cycle counts as edge 0 of the start bit.
                    state_d    = S_START;
                    edge_cnt_d = 6'd1;
                    pre_d      = rx.Prescale;
                    par_en_d   = rx.PAR_EN;
                    par_typ_d  = rx.PAR_TYP;
                    par_err_d  = 1'b0;
                    stp_err_d  = 1'b0;
                end
            end
            S_START: begin
                if (last_edge) begin
                    if (maj_reg) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (last_edge) begin
                    shift_d[bit_cnt_q] = maj_reg;
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (last_edge) begin
                    par_err_d = (maj_reg != ((^shift_q) ^ par_typ_q));
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // Leave half a bit early so a back-to-back start edge is not missed.
                if (edge_cnt_q == half + 6'd1) begin
                    stp_err_d  = ~maj_stop;
                    if (maj_stop && !par_err_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    state_d    = S_IDLE;
                    edge_cnt_d = 6'd0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            pre_q        <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            samp_q       <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            pre_q        <= pre_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign rx.P_DATA     = p_data_q;
    assign rx.data_valid = data_valid_q;
    assign rx.par_err    = par_err_q;
    assign rx.stp_err    = stp_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-decoding reference model
module tb_uart_rx;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst_n),
        .rx  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        int         kind;   // 0 clear errors, 1 parity result, 2 stop result
        bit         v;
        bit         dv;
        logic [7:0] data;
    } ev_t;

    ev_t  evq[$];
    bit   wave[$];
    ev_t  e;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    logic [7:0] exp_pdata = 8'h00;
    bit   exp_par = 1'b0;
    bit   exp_stp = 1'b0;
    bit   exp_dv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Waveform builders: one queue entry per clock cycle of line level.
    function automatic void add_idle(input int n);
        repeat (n) wave.push_back(1'b1);
    endfunction

    function automatic void add_frame(input int p, input logic [7:0] d, input bit pe,
                                      input bit pt, input bit flip, input bit stop_v);
        repeat (p) wave.push_back(1'b0);
        for (int b = 0; b < 8; b++) repeat (p) wave.push_back(d[b]);
        if (pe) repeat (p) wave.push_back((^d) ^ pt ^ flip);
        if (stop_v) begin
            repeat (p) wave.push_back(1'b1);
        end else begin
            // low only across the sampling window, so no false start follows
            repeat (p / 2 + 2) wave.push_back(1'b0);
            repeat (p - p / 2 - 2) wave.push_back(1'b1);
        end
    endfunction

    function automatic bit lvl(input int j);
        return (j < wave.size()) ? wave[j] : 1'b1;
    endfunction

    function automatic bit vote(input int j);
        bit a, b, c;
        a = lvl(j); b = lvl(j + 1); c = lvl(j + 2);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Decode the waveform as a UART line and schedule the visible output changes.
    function automatic void decode(input int base, input int p, input bit pe, input bit pt);
        int i, h, k, s;
        logic [7:0] d;
        bit perr, stop_ok, pbit;
        ev_t ev;
        i = 0;
        h = p / 2;
        while (i < wave.size()) begin
            if (wave[i]) begin
                i++;
                continue;
            end
            ev = '{at: base + i + 1, kind: 0, v: 1'b0, dv: 1'b0, data: 8'h00};
            evq.push_back(ev);
            if (vote(i + h - 1)) begin
                i += p;
                continue;
            end
            for (int b = 0; b < 8; b++) d[b] = vote(i + (1 + b) * p + h - 1);
            perr = 1'b0;
            k = 9;
            if (pe) begin
                pbit = vote(i + 9 * p + h - 1);
                perr = (pbit != ((^d) ^ pt));
                ev = '{at: base + i + 10 * p, kind: 1, v: perr, dv: 1'b0, data: 8'h00};
                evq.push_back(ev);
                k = 10;
            end
            stop_ok = vote(i + k * p + h - 1);
            s = i + k * p + h + 1;
            ev = '{at: base + s + 1, kind: 2, v: !stop_ok, dv: stop_ok && !perr, data: d};
            evq.push_back(ev);
            i = s + 1;
        end
    endfunction

    task automatic run_wave(input int p, input bit pe, input bit pt);
        @(posedge clk); #1;
        bus.Prescale = 6'(p);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        decode(cyc, p, pe, pt);
        for (int j = 0; j < wave.size(); j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            bus.RX_IN = wave[j];
        end
        @(posedge clk); #1;
        bus.RX_IN = 1'b1;
        wave.delete();
    endtask

    task automatic drive_raw(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            bus.RX_IN = wave[j];
        end
        wave.delete();
    endtask

    // Compare process: model state against DUT outputs every cycle.
    always @(negedge clk) begin
        exp_dv = 1'b0;
        if (!rst_n) begin
            exp_pdata = 8'h00;
            exp_par   = 1'b0;
            exp_stp   = 1'b0;
        end
        while (evq.size() > 0 && evq[0].at <= cyc) begin
            e = evq.pop_front();
            case (e.kind)
                0: begin exp_par = 1'b0; exp_stp = 1'b0; end
                1: exp_par = e.v;
                default: begin
                    exp_stp = e.v;
                    if (e.dv) begin
                        exp_pdata = e.data;
                        if (e.at == cyc) exp_dv = 1'b1;
                    end
                end
            endcase
        end
        chk("data_valid", bus.data_valid, exp_dv);
        chk("P_DATA", bus.P_DATA, exp_pdata);
        chk("par_err", bus.par_err, exp_par);
        chk("stp_err", bus.stp_err, exp_stp);
        if (bus.data_valid === 1'b1) pulses++;
    end

    initial begin
        bus.RX_IN    = 1'b1;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        bus.Prescale = 6'd8;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_P_DATA", bus.P_DATA, 0);
        chk("rst_data_valid", bus.data_valid, 0);
        chk("rst_par_err", bus.par_err, 0);
        chk("rst_stp_err", bus.stp_err, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // T1: Prescale 8, no parity, 0xA5
        add_idle(4); add_frame(8, 8'hA5, 0, 0, 0, 1); add_idle(12);
        run_wave(8, 0, 0);
        chk("t1_data", bus.P_DATA, 8'hA5);
        chk("t1_pulses", pulses, 1);
        chk("t1_errs", {bus.par_err, bus.stp_err}, 0);

        // T2: Prescale 16, even parity, good then bad parity bit
        add_frame(16, 8'h3C, 1, 0, 0, 1); add_idle(20);
        run_wave(16, 1, 0);
        chk("t2_data", bus.P_DATA, 8'h3C);
        chk("t2_pulses", pulses, 2);
        add_frame(16, 8'h3C, 1, 0, 1, 1); add_idle(20);
        run_wave(16, 1, 0);
        chk("t2_par_err", bus.par_err, 1);
        chk("t2_bad_pulses", pulses, 2);
        chk("t2_data_held", bus.P_DATA, 8'h3C);

        // T3: stop bit driven low, then a good frame clears it
        add_frame(8, 8'h81, 0, 0, 0, 0); add_idle(12);
        run_wave(8, 0, 0);
        chk("t3_stp_err", bus.stp_err, 1);
        chk("t3_par_err", bus.par_err, 0);
        chk("t3_pulses", pulses, 2);
        chk("t3_data_held", bus.P_DATA, 8'h3C);
        add_frame(8, 8'h81, 0, 0, 0, 1); add_idle(12);
        run_wave(8, 0, 0);
        chk("t3_stp_clear", bus.stp_err, 0);
        chk("t3_data", bus.P_DATA, 8'h81);

        // T4: short start glitch, then a one-cycle spike on a data bit
        wave.push_back(1'b0); wave.push_back(1'b0); add_idle(20);
        run_wave(8, 0, 0);
        chk("t4_glitch_pulses", pulses, 3);
        chk("t4_glitch_data", bus.P_DATA, 8'h81);
        add_idle(2); add_frame(16, 8'hC3, 0, 0, 0, 1); add_idle(20);
        wave[2 + 3 * 16 + 8] = 1'b1;
        run_wave(16, 0, 0);
        chk("t4_spike_data", bus.P_DATA, 8'hC3);
        chk("t4_spike_pulses", pulses, 4);

        // T5: Prescale 32, odd parity, back-to-back frames
        add_frame(32, 8'h00, 1, 1, 0, 1);
        add_frame(32, 8'hFF, 1, 1, 0, 1);
        add_frame(32, 8'h55, 1, 1, 0, 1);
        add_idle(40);
        run_wave(32, 1, 1);
        chk("t5_data", bus.P_DATA, 8'h55);
        chk("t5_pulses", pulses, 7);
        chk("t5_errs", {bus.par_err, bus.stp_err}, 0);

        // T6: reset in the middle of data bit 4, then a clean 0x5A
        add_frame(8, 8'h5A, 0, 0, 0, 1);
        drive_raw(5 * 8 + 4);
        #1;
        rst_n     = 1'b0;
        bus.RX_IN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_rst_P_DATA", bus.P_DATA, 0);
        chk("t6_rst_valid", bus.data_valid, 0);
        chk("t6_rst_errs", {bus.par_err, bus.stp_err}, 0);
        rst_n = 1'b1;
        chk("t6_abort_pulses", pulses, 7);
        add_idle(3); add_frame(8, 8'h5A, 0, 0, 0, 1); add_idle(12);
        run_wave(8, 0, 0);
        chk("t6_data", bus.P_DATA, 8'h5A);
        chk("t6_pulses", pulses, 8);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
